// File: rtl/adder_axil_sequencer.sv
// adder_axil_sequencer: round-robin sharing of one AXI4-Lite adder among NUM_REQ requesters
// Ports: ACLK, ARESET (async, active-high); req_valid/req_ready/req_opnd ({B,A} per requester);
//   rsp_valid/rsp_data/rsp_err (one-hot result pulse); m00_axi_* AXI4-Lite master to the adder.
// Macro ADDER_SEQ_TIMEOUT_EN bounds every AXI wait to TIMEOUT_CYC cycles.
module adder_axil_sequencer #(
  parameter int          NUM_REQ     = 4,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 256
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [64*NUM_REQ-1:0]  req_opnd,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic [31:0]            m00_axi_awaddr,
  output logic                   m00_axi_awvalid,
  input  logic                   m00_axi_awready,
  output logic [31:0]            m00_axi_wdata,
  output logic                   m00_axi_wvalid,
  input  logic                   m00_axi_wready,
  input  logic [1:0]             m00_axi_bresp,
  input  logic                   m00_axi_bvalid,
  output logic                   m00_axi_bready,
  output logic [31:0]            m00_axi_araddr,
  output logic                   m00_axi_arvalid,
  input  logic                   m00_axi_arready,
  input  logic [31:0]            m00_axi_rdata,
  input  logic [1:0]             m00_axi_rresp,
  input  logic                   m00_axi_rvalid,
  output logic                   m00_axi_rready
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [2:0] S_IDLE = 3'd0, S_AW_A = 3'd1, S_B_A = 3'd2, S_AW_B = 3'd3,
                         S_B_B  = 3'd4, S_AR   = 3'd5, S_R   = 3'd6, S_RSP  = 3'd7;
  logic [2:0]         r_state, w_nxt;
  logic [IW-1:0]      r_ptr, r_gnt, w_gnt;
  logic [IW:0]        w_sum;
  logic [NUM_REQ-1:0] w_rot;
  logic               w_any, w_aw_done, w_enter_aw, w_to;
  logic [31:0]        r_a, r_b, r_data;
  logic               r_err, r_awvalid, r_wvalid;
  // w_rot[k] is the request k positions after r_ptr; a descending scan leaves the nearest one granted
  assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_ptr);
  always_comb begin
    w_any = 1'b0;
    w_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_rot[k]) begin
        w_any = 1'b1;
        w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      end
    w_gnt = IW'((w_sum >= (IW+1)'(NUM_REQ)) ? w_sum - (IW+1)'(NUM_REQ) : w_sum);
  end
  // each channel is done once its valid has dropped or is being accepted this cycle
  assign w_aw_done = (!r_awvalid || m00_axi_awready) && (!r_wvalid || m00_axi_wready);
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: w_nxt = w_any ? S_AW_A : S_IDLE;
      S_AW_A: w_nxt = w_aw_done ? S_B_A : S_AW_A;
      S_B_A:  w_nxt = !m00_axi_bvalid ? S_B_A : (|m00_axi_bresp) ? S_RSP : S_AW_B;
      S_AW_B: w_nxt = w_aw_done ? S_B_B : S_AW_B;
      S_B_B:  w_nxt = !m00_axi_bvalid ? S_B_B : (|m00_axi_bresp) ? S_RSP : S_AR;
      S_AR:   w_nxt = m00_axi_arready ? S_R : S_AR;
      S_R:    w_nxt = m00_axi_rvalid ? S_RSP : S_R;
      default: w_nxt = S_IDLE;
    endcase
    if (w_to) w_nxt = S_RSP;
  end
  assign w_enter_aw = (w_nxt == S_AW_A || w_nxt == S_AW_B) && w_nxt != r_state;
`ifdef ADDER_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tcnt;
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) r_tcnt <= '0;
    else r_tcnt <= (w_nxt != r_state) ? '0 : r_tcnt + TW'(1);
  assign w_to = r_state != S_IDLE && r_state != S_RSP && r_tcnt == TW'(TIMEOUT_CYC - 1);
`else
  logic w_unused_to;
  assign w_unused_to = |TIMEOUT_CYC;
  assign w_to = 1'b0;
`endif
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_awvalid <= w_enter_aw | (r_awvalid & ~m00_axi_awready & ~w_to);
      r_wvalid  <= w_enter_aw | (r_wvalid & ~m00_axi_wready & ~w_to);
      if (r_state == S_IDLE && w_any) begin
        r_gnt <= w_gnt;
        r_a   <= req_opnd[{w_gnt, 6'd0} +: 32];
        r_b   <= req_opnd[{w_gnt, 6'd32} +: 32];
      end
      if (w_nxt == S_RSP && r_state != S_RSP) r_ptr <= (r_gnt == IW'(NUM_REQ - 1)) ? '0 : r_gnt + IW'(1);
      if (w_to) begin
        r_err  <= 1'b1;
        r_data <= '1;
      end else if ((r_state == S_B_A || r_state == S_B_B) && m00_axi_bvalid && |m00_axi_bresp) begin
        r_err  <= 1'b1;
        r_data <= '0;
      end else if (r_state == S_R && m00_axi_rvalid) begin
        r_err  <= |m00_axi_rresp;
        r_data <= m00_axi_rdata;
      end
    end
  assign req_ready       = (r_state == S_IDLE && w_any && !ARESET) ? NUM_REQ'(1) << w_gnt : '0;
  assign rsp_valid       = (r_state == S_RSP) ? NUM_REQ'(1) << r_gnt : '0;
  assign rsp_data        = r_data;
  assign rsp_err         = r_err;
  assign m00_axi_awvalid = r_awvalid;
  assign m00_axi_wvalid  = r_wvalid;
  assign m00_axi_awaddr  = (r_state == S_AW_A) ? ADDR_BASE : (r_state == S_AW_B) ? ADDR_BASE + 32'h4 : '0;
  assign m00_axi_wdata   = (r_state == S_AW_A) ? r_a : (r_state == S_AW_B) ? r_b : '0;
  assign m00_axi_bready  = r_state == S_B_A || r_state == S_B_B;
  assign m00_axi_arvalid = r_state == S_AR;
  assign m00_axi_araddr  = (r_state == S_AR) ? ADDR_BASE + 32'h8 : '0;
  assign m00_axi_rready  = r_state == S_R;
endmodule

// File: tb/tb_adder_axil_sequencer.sv
// tb_adder_axil_sequencer: directed checks of the sequencer against a small AXI4-Lite adder slave
module tb_adder_axil_sequencer;
  localparam int N = 4;
`ifdef ADDER_SEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [64*N-1:0] req_opnd;
  logic [31:0] rsp_data, m00_axi_awaddr, m00_axi_wdata, m00_axi_araddr, m00_axi_rdata;
  logic rsp_err, m00_axi_awvalid, m00_axi_awready, m00_axi_wvalid, m00_axi_wready;
  logic m00_axi_bvalid, m00_axi_bready, m00_axi_arvalid, m00_axi_arready, m00_axi_rvalid, m00_axi_rready;
  logic [1:0] m00_axi_bresp, m00_axi_rresp;
  adder_axil_sequencer #(.NUM_REQ(N), .ADDR_BASE(32'h0), .TIMEOUT_CYC(TO)) dut (
    .ACLK(clk), .ARESET(rst), .req_valid(req_valid), .req_ready(req_ready), .req_opnd(req_opnd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m00_axi_awaddr(m00_axi_awaddr), .m00_axi_awvalid(m00_axi_awvalid), .m00_axi_awready(m00_axi_awready),
    .m00_axi_wdata(m00_axi_wdata), .m00_axi_wvalid(m00_axi_wvalid), .m00_axi_wready(m00_axi_wready),
    .m00_axi_bresp(m00_axi_bresp), .m00_axi_bvalid(m00_axi_bvalid), .m00_axi_bready(m00_axi_bready),
    .m00_axi_araddr(m00_axi_araddr), .m00_axi_arvalid(m00_axi_arvalid), .m00_axi_arready(m00_axi_arready),
    .m00_axi_rdata(m00_axi_rdata), .m00_axi_rresp(m00_axi_rresp), .m00_axi_rvalid(m00_axi_rvalid),
    .m00_axi_rready(m00_axi_rready));
  int nchk = 0, nerr = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // adder slave: AWREADY after aw_dly waiting cycles, WREADY after w_dly, B the cycle after both beats
  int aw_dly, w_dly, s_aww, s_ww, aw_cnt, ar_cnt, b_cnt, awv_cyc, wv_cyc;
  logic [1:0] err_a;
  logic r_mute, s_awg, s_wg, aw_hs, w_hs;
  logic [31:0] s_awa, s_wd, reg_a, reg_b, last_ar, wr_a, wr_d;
  assign m00_axi_awready = m00_axi_awvalid && !s_awg && !m00_axi_bvalid && s_aww >= aw_dly;
  assign m00_axi_wready  = m00_axi_wvalid && !s_wg && !m00_axi_bvalid && s_ww >= w_dly;
  assign m00_axi_arready = m00_axi_arvalid && !m00_axi_rvalid;
  assign m00_axi_rresp   = 2'b00;
  assign aw_hs = m00_axi_awvalid && m00_axi_awready;
  assign w_hs  = m00_axi_wvalid && m00_axi_wready;
  assign wr_a  = aw_hs ? m00_axi_awaddr : s_awa;
  assign wr_d  = w_hs ? m00_axi_wdata : s_wd;
  always @(posedge clk or posedge rst)
    if (rst) begin
      s_awg <= 0; s_wg <= 0; s_aww <= 0; s_ww <= 0; s_awa <= 0; s_wd <= 0;
      reg_a <= 0; reg_b <= 0; last_ar <= 0; m00_axi_bvalid <= 0; m00_axi_bresp <= 0;
      m00_axi_rvalid <= 0; m00_axi_rdata <= 0;
    end else begin
      if (m00_axi_awvalid) awv_cyc <= awv_cyc + 1;
      if (m00_axi_wvalid) wv_cyc <= wv_cyc + 1;
      if (aw_hs) begin s_awg <= 1; s_awa <= m00_axi_awaddr; s_aww <= 0; aw_cnt <= aw_cnt + 1; end
      else if (m00_axi_awvalid && !s_awg) s_aww <= s_aww + 1;
      if (w_hs) begin s_wg <= 1; s_wd <= m00_axi_wdata; s_ww <= 0; end
      else if (m00_axi_wvalid && !s_wg) s_ww <= s_ww + 1;
      if (m00_axi_bvalid && m00_axi_bready) begin m00_axi_bvalid <= 0; b_cnt <= b_cnt + 1; end
      if ((s_awg || aw_hs) && (s_wg || w_hs)) begin
        s_awg <= 0; s_wg <= 0; m00_axi_bvalid <= 1;
        m00_axi_bresp <= (wr_a == 32'h0) ? err_a : 2'b00;
        if (wr_a == 32'h0) reg_a <= wr_d;
        if (wr_a == 32'h4) reg_b <= wr_d;
      end
      if (m00_axi_rvalid && m00_axi_rready) m00_axi_rvalid <= 0;
      if (m00_axi_arvalid && m00_axi_arready) begin
        ar_cnt <= ar_cnt + 1; last_ar <= m00_axi_araddr;
        if (!r_mute) begin m00_axi_rvalid <= 1; m00_axi_rdata <= reg_a + reg_b; end
      end
    end
  logic [N-1:0] last_rv;
  logic [31:0] last_rd;
  always @(negedge clk) if (rsp_valid != '0) begin last_rv <= rsp_valid; last_rd <= rsp_data; end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_gnt(output logic [N-1:0] g, output int t);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 50) begin @(negedge clk); #1; n++; end
    g = req_ready;
    t = cyc;
  endtask
  task automatic wait_rsp(output logic [N-1:0] v, output logic [31:0] d, output logic e, output int t);
    int n = 0;
    while (rsp_valid == '0 && n < 100) begin @(negedge clk); n++; end
    v = rsp_valid; d = rsp_data; e = rsp_err; t = cyc;
  endtask
  task automatic xact(input string tag, input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
    logic [N-1:0] g, v;
    logic [31:0] d;
    logic e;
    int t0, t1;
    @(negedge clk);
    req_opnd[64*i +: 64] = {b, a};
    req_valid[i] = 1'b1;
    wait_gnt(g, t0);
    chk({tag, ".gnt"}, g, 4'b1 << i);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    wait_rsp(v, d, e, t1);
    chk({tag, ".rsp_v"}, v, 4'b1 << i);
    chk({tag, ".rsp_d"}, d, exp_d);
    chk({tag, ".rsp_e"}, e, exp_e);
    chk({tag, ".lat"}, t1 - t0, exp_lat);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [N-1:0] g, v;
    logic [31:0] d;
    logic e;
    int t, n, s0, s1, s2, s3;
    rst = 1; req_valid = '0; req_opnd = '0; aw_dly = 0; w_dly = 0; err_a = 2'b00; r_mute = 0;
    aw_cnt = 0; ar_cnt = 0; b_cnt = 0; awv_cyc = 0; wv_cyc = 0;
    repeat (3) @(negedge clk);
    req_valid = '1;
    #1 chk("rst.ctl", {req_ready, rsp_valid, m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready,
                       m00_axi_arvalid, m00_axi_rready}, 0);
    req_valid = '0;
    @(negedge clk) rst = 0;
    #1 chk("idle.ctl", {req_ready, rsp_valid, m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready,
                        m00_axi_arvalid, m00_axi_rready}, 0);
    chk("idle.data", {rsp_err, rsp_data}, 0);
    // round robin with every requester held high, then only 2 and 0 with the pointer at 1
    for (int i = 0; i < N; i++) req_opnd[64*i +: 64] = {32'(i + 1), 32'h1000_0000 * i + 32'd3};
    @(negedge clk) req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g, t);
      chk($sformatf("t2.gnt%0d", k), g, 4'b1 << (k % 4));
      @(posedge clk);
    end
    #1 req_valid = 4'b0101;
    wait_gnt(g, t);
    chk("t2.gnt_r2", g, 4'b0100);
    @(posedge clk);
    wait_gnt(g, t);
    chk("t2.gnt_r0", g, 4'b0001);
    chk("t2.rsp2_v", last_rv, 4'b0100);
    chk("t2.rsp2_d", last_rd, 32'h2000_0006);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(v, d, e, t);
    chk("t2.rsp0_v", v, 4'b0001);
    chk("t2.rsp0_d", d, 32'd4);
    // basic add, zero-wait slave
    xact("t1", 0, 32'd5, 32'd7, 32'd12, 1'b0, 7);
    chk("t1.reg_a", reg_a, 32'd5);
    chk("t1.reg_b", reg_b, 32'd7);
    chk("t1.araddr", last_ar, 32'h8);
    // error on the A write: B write and read skipped
    err_a = 2'b10; s0 = aw_cnt; s1 = ar_cnt;
    xact("t3b", 1, 32'd9, 32'd9, 32'd0, 1'b1, 3);
    chk("t3b.aw_cnt", aw_cnt - s0, 1);
    chk("t3b.ar_cnt", ar_cnt - s1, 0);
    err_a = 2'b00;
    // wrap-around sum
    xact("t3a", 2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 7);
    // AWREADY late, WREADY immediate
    aw_dly = 3; s0 = awv_cyc; s1 = wv_cyc; s2 = b_cnt; s3 = aw_cnt;
    xact("t4", 2, 32'd100, 32'd23, 32'd123, 1'b0, 13);
    chk("t4.awv_cyc", awv_cyc - s0, 8);
    chk("t4.wv_cyc", wv_cyc - s1, 2);
    chk("t4.b_cnt", b_cnt - s2, 2);
    chk("t4.aw_cnt", aw_cnt - s3, 2);
    aw_dly = 0;
    // reset while waiting in R; pointer returns to 0
    r_mute = 1;
    @(negedge clk);
    req_opnd[64*3 +: 64] = {32'd1, 32'd1};
    req_valid[3] = 1'b1;
    wait_gnt(g, t);
    chk("t5.gnt", g, 4'b1000);
    @(posedge clk);
    #1 req_valid = '0;
    n = 0;
    while (!m00_axi_rready && n < 50) begin @(negedge clk); n++; end
    chk("t5.in_r", m00_axi_rready, 1'b1);
    rst = 1;
    #1 chk("t5.abort", {req_ready, rsp_valid, m00_axi_awvalid, m00_axi_wvalid, m00_axi_bready,
                        m00_axi_arvalid, m00_axi_rready}, 0);
    @(negedge clk) rst = 0;
    r_mute = 0;
    req_opnd[64*1 +: 64] = {32'd2, 32'd40};
    req_valid = 4'b1010;
    wait_gnt(g, t);
    chk("t5.gnt_after", g, 4'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(v, d, e, t);
    chk("t5.rsp_v", v, 4'b0010);
    chk("t5.rsp_d", d, 32'd42);
`ifdef ADDER_SEQ_TIMEOUT_EN
    // RVALID never comes: 16 cycles in R then error response
    r_mute = 1;
    xact("t6", 0, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1, 22);
    r_mute = 0;
`endif
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
